// File: rtl/instr_encode_loader_pkg.sv
// Shared ISA definitions for the instruction encoder/loader: field widths, class codes, sub-op codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_encode_loader_pkg;

  localparam int WORD_W  = 9;
  localparam int TYPE_W  = 2;
  localparam int SUBOP_W = 3;
  localparam int OPND_W  = 6;

  // Instruction class, occupies word[8:7]
  typedef enum logic [TYPE_W-1:0] {
    MATH = 2'b00,
    COND = 2'b01,
    ASGN = 2'b10,
    VAL  = 2'b11
  } instr_type_e;

  // Math sub-ops (3 bits, all legal)
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  // Conditional branch sub-ops (2 bits)
  localparam logic [1:0] OP_BL  = 2'd0;
  localparam logic [1:0] OP_BG  = 2'd1;
  localparam logic [1:0] OP_BNE = 2'd2;
  localparam logic [1:0] OP_BEQ = 2'd3;

  // Assign/memory sub-ops (3 bits); 001, 110 and 111 are reserved
  localparam logic [2:0] OP_LI    = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_CMP   = 3'd4;
  localparam logic [2:0] OP_NOP   = 3'd5;

  // One bit per A-class sub-op value, set where the decoder treats it as reserved
  localparam logic [7:0] ASGN_RSVD_MASK = 8'b1100_0010;

  // Move/jump sub-op (1 bit)
  localparam logic OP_MOV = 1'b0;
  localparam logic OP_JMP = 1'b1;

  // Loader session state
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_encode_loader_if.sv
// Request channel carrying symbolic instructions from host to loader.
// Latency: n/a (wires only).
// Backpressure: valid/ready; a transfer happens when both are high at a clock edge.
interface instr_encode_loader_if;
  import instr_encode_loader_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [TYPE_W-1:0]    req_type;
  logic [SUBOP_W-1:0]   req_subop;
  logic [OPND_W-1:0]    req_operand;

  modport master (
    output req_valid,
    output req_type,
    output req_subop,
    output req_operand,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_type,
    input  req_subop,
    input  req_operand,
    output req_ready
  );

endinterface

// File: rtl/instr_encode_loader_packer.sv
// Packs class/sub-op/operand into a 9-bit machine word and flags illegal encodings.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is used.
module instr_packer
  import instr_encode_loader_pkg::*;
(
  input  logic [TYPE_W-1:0]  req_type,
  input  logic [SUBOP_W-1:0] subop,
  input  logic [OPND_W-1:0]  operand,
  output logic [WORD_W-1:0]  word,
  output logic               illegal_subop,
  output logic               operand_ovf
);

  // Field layout and legality check per instruction class
  always_comb begin
    word          = '0;
    illegal_subop = 1'b0;
    operand_ovf   = 1'b0;
    case (instr_type_e'(req_type))
      MATH: begin
        word        = {MATH, subop, operand[3:0]};
        operand_ovf = |operand[5:4];
      end
      COND: begin
        word          = {COND, subop[1:0], operand[4:0]};
        illegal_subop = subop[2];
        operand_ovf   = operand[5];
      end
      ASGN: begin
        word          = {ASGN, subop, operand[3:0]};
        illegal_subop = ASGN_RSVD_MASK[subop];
        operand_ovf   = |operand[5:4];
      end
      VAL: begin
        word          = {VAL, subop[0], operand};
        illegal_subop = |subop[2:1];
      end
      default: begin
        word = '0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes symbolic requests and writes them to instruction memory at consecutive addresses.
// Latency: one cycle from accept to im_we strobe; one accept per cycle with no bubbles.
// Backpressure: req_ready low outside LOAD, once finish is pending, or when DEPTH words are written.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [AW-1:0]         start_addr,
  input  logic                  finish,
  instr_encode_loader_if.slave  req,
  output logic                  im_we,
  output logic [AW-1:0]         im_addr,
  output logic [WORD_W-1:0]     im_wdata,
  output logic [AW:0]           word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_e              state;
  logic [AW-1:0]       addr;
  logic                finish_pending;
  logic [WORD_W-1:0]   word;
  logic                illegal_subop;
  logic                operand_ovf;
  logic                accept;
  logic                bad;

  instr_packer u_packer (
    .req_type      (req.req_type),
    .subop         (req.req_subop),
    .operand       (req.req_operand),
    .word          (word),
    .illegal_subop (illegal_subop),
    .operand_ovf   (operand_ovf)
  );

  assign req.req_ready = (state == S_LOAD) && !finish_pending && (word_count < DEPTH_W);
  assign accept        = req.req_valid && req.req_ready;
  assign bad           = illegal_subop || operand_ovf;

  assign busy = (state == S_LOAD);
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

  // Session FSM, address/count tracking and the one-deep write stage.
  // Leaving LOAD for DONE is only done on a cycle with no accept, so a strobe
  // launched by the final accept always completes before done rises.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= S_IDLE;
      addr           <= '0;
      word_count     <= '0;
      err_code       <= '0;
      finish_pending <= 1'b0;
      im_we          <= 1'b0;
      im_addr        <= '0;
      im_wdata       <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept && bad) begin
            state          <= S_ERR;
            err_code       <= {operand_ovf, illegal_subop};
            finish_pending <= 1'b0;
          end else if (accept) begin
            im_we      <= 1'b1;
            im_addr    <= addr;
            im_wdata   <= word;
            addr       <= addr + 1'b1;
            word_count <= word_count + 1'b1;
            if (finish) begin
              finish_pending <= 1'b1;
            end
          end else if (finish || finish_pending || (word_count >= DEPTH_W)) begin
            state          <= S_DONE;
            finish_pending <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            state          <= S_LOAD;
            addr           <= start_addr;
            word_count     <= '0;
            err_code       <= '0;
            finish_pending <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: encoding table plus session corner cases.
// Expected writes are queued when a request is driven and popped when im_we is seen.
// DUT built with DEPTH=4 so the depth limit is reachable in a short run.
module tb_instr_encode_loader;
  import instr_encode_loader_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            start;
  logic [AW-1:0]   start_addr;
  logic            finish;
  logic            im_we;
  logic [AW-1:0]   im_addr;
  logic [8:0]      im_wdata;
  logic [AW:0]     word_count;
  logic            busy;
  logic            done;
  logic            err;
  logic [1:0]      err_code;

  instr_encode_loader_if rq();

  instr_encode_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .start_addr (start_addr),
    .finish     (finish),
    .req        (rq),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [8:0]    data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [1:0] t;
    logic [2:0] s;
    logic [5:0] o;
    logic       ok;
    logic [8:0] word;
    logic [1:0] ec;
  } vec_t;
  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation
  always @(negedge Clk) begin
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h@%0h required=none", im_wdata, im_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(im_addr), 32'(e.addr));
        chk("wr_data", 32'(im_wdata), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start      = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  // Drive one request for one cycle; queue the write if it is expected to land
  task automatic send(input logic [1:0] t, input logic [2:0] s, input logic [5:0] o,
                      input logic exp_rdy, input logic do_push,
                      input logic [AW-1:0] a, input logic [8:0] w);
    rq.req_valid   = 1'b1;
    rq.req_type    = t;
    rq.req_subop   = s;
    rq.req_operand = o;
    @(negedge Clk);
    chk("req_ready", 32'(rq.req_ready), 32'(exp_rdy));
    if (do_push) exp_q.push_back('{a, w});
    @(posedge Clk);
    #1;
    rq.req_valid = 1'b0;
  endtask

  initial begin
    Reset          = 1'b1;
    start          = 1'b0;
    start_addr     = '0;
    finish         = 1'b0;
    rq.req_valid   = 1'b0;
    rq.req_type    = '0;
    rq.req_subop   = '0;
    rq.req_operand = '0;

    vecs = '{
      '{2'b00, 3'b000, 6'h03, 1'b1, 9'h003, 2'b00},
      '{2'b00, 3'b111, 6'h0F, 1'b1, 9'h07F, 2'b00},
      '{2'b00, 3'b010, 6'h10, 1'b0, 9'h000, 2'b10},
      '{2'b01, 3'b011, 6'h05, 1'b1, 9'h0E5, 2'b00},
      '{2'b01, 3'b000, 6'h1F, 1'b1, 9'h09F, 2'b00},
      '{2'b01, 3'b100, 6'h01, 1'b0, 9'h000, 2'b01},
      '{2'b01, 3'b000, 6'h20, 1'b0, 9'h000, 2'b10},
      '{2'b01, 3'b111, 6'h21, 1'b0, 9'h000, 2'b11},
      '{2'b10, 3'b000, 6'h09, 1'b1, 9'h109, 2'b00},
      '{2'b10, 3'b010, 6'h04, 1'b1, 9'h124, 2'b00},
      '{2'b10, 3'b101, 6'h0F, 1'b1, 9'h15F, 2'b00},
      '{2'b10, 3'b001, 6'h00, 1'b0, 9'h000, 2'b01},
      '{2'b10, 3'b111, 6'h30, 1'b0, 9'h000, 2'b11},
      '{2'b11, 3'b001, 6'h2A, 1'b1, 9'h1EA, 2'b00},
      '{2'b11, 3'b000, 6'h3F, 1'b1, 9'h1BF, 2'b00},
      '{2'b11, 3'b010, 6'h00, 1'b0, 9'h000, 2'b01},
      '{2'b11, 3'b100, 6'h3F, 1'b0, 9'h000, 2'b01},
      '{2'b10, 3'b110, 6'h00, 1'b0, 9'h000, 2'b01}
    };

    repeat (3) tick();
    // Reset state
    chk("rst_we", 32'(im_we), 0);
    chk("rst_addr", 32'(im_addr), 0);
    chk("rst_wdata", 32'(im_wdata), 0);
    chk("rst_count", 32'(word_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ec", 32'(err_code), 0);
    chk("rst_ready", 32'(rq.req_ready), 0);
    Reset = 1'b0;
    tick();

    // Idle ignores requests
    send(2'b00, 3'b000, 6'h01, 1'b0, 1'b0, '0, '0);

    // Back-to-back add/beq/li/jmp at address 0; DEPTH reached after the fourth
    do_start(10'h000);
    chk("t1_busy", 32'(busy), 1);
    send(2'b00, 3'b000, 6'd3,  1'b1, 1'b1, 10'h000, 9'h003);
    chk("t1_we0", 32'(im_we), 1);
    send(2'b01, 3'b011, 6'd5,  1'b1, 1'b1, 10'h001, 9'h0E5);
    chk("t1_we1", 32'(im_we), 1);
    send(2'b10, 3'b000, 6'd9,  1'b1, 1'b1, 10'h002, 9'h109);
    chk("t1_we2", 32'(im_we), 1);
    send(2'b11, 3'b001, 6'd42, 1'b1, 1'b1, 10'h003, 9'h1EA);
    chk("t1_we3", 32'(im_we), 1);
    chk("t1_count", 32'(word_count), 4);
    chk("t1_busy_strobe", 32'(busy), 1);
    chk("t1_ready_full", 32'(rq.req_ready), 0);
    tick();
    chk("t1_done", 32'(done), 1);

    // Reserved A-class sub-op, then operand overflow after restart
    do_start(10'h040);
    send(2'b10, 3'b110, 6'h00, 1'b1, 1'b0, '0, '0);
    chk("t2_err", 32'(err), 1);
    chk("t2_ec", 32'(err_code), 1);
    chk("t2_ready", 32'(rq.req_ready), 0);
    tick();
    chk("t2_err_hold", 32'(err), 1);
    do_finish();
    chk("t2_finish_ignored", 32'(err), 1);
    do_start(10'h040);
    send(2'b00, 3'b000, 6'h10, 1'b1, 1'b0, '0, '0);
    chk("t2_ec_ovf", 32'(err_code), 2);

    // Address wrap and depth limit
    do_start(10'h3FE);
    send(2'b00, 3'b001, 6'h1, 1'b1, 1'b1, 10'h3FE, 9'h011);
    send(2'b00, 3'b001, 6'h2, 1'b1, 1'b1, 10'h3FF, 9'h012);
    send(2'b00, 3'b001, 6'h3, 1'b1, 1'b1, 10'h000, 9'h013);
    send(2'b00, 3'b001, 6'h4, 1'b1, 1'b1, 10'h001, 9'h014);
    send(2'b00, 3'b001, 6'h5, 1'b0, 1'b0, '0, '0);
    chk("t3_done", 32'(done), 1);
    chk("t3_count", 32'(word_count), 4);

    // Finish together with an accepted mov
    do_start(10'h080);
    finish = 1'b1;
    send(2'b11, 3'b000, 6'd7, 1'b1, 1'b1, 10'h080, 9'h187);
    finish = 1'b0;
    chk("t4_we", 32'(im_we), 1);
    chk("t4_ready", 32'(rq.req_ready), 0);
    tick();
    chk("t4_done", 32'(done), 1);
    chk("t4_ready_done", 32'(rq.req_ready), 0);

    // Encoding table: one fresh session per vector
    for (int i = 0; i < 18; i++) begin
      logic [AW-1:0] a;
      a = 10'(10'h100 + i);
      do_start(a);
      send(vecs[i].t, vecs[i].s, vecs[i].o, 1'b1, vecs[i].ok, a, vecs[i].word);
      if (vecs[i].ok) begin
        chk("tab_err", 32'(err), 0);
        chk("tab_count", 32'(word_count), 1);
        do_finish();
        chk("tab_done", 32'(done), 1);
      end else begin
        chk("tab_err", 32'(err), 1);
        chk("tab_ec", 32'(err_code), 32'(vecs[i].ec));
        chk("tab_busy", 32'(busy), 0);
      end
    end

    // Start while busy is ignored; start from ERR clears the error
    do_start(10'h010);
    send(2'b00, 3'b000, 6'd1, 1'b1, 1'b1, 10'h010, 9'h001);
    start      = 1'b1;
    start_addr = 10'h200;
    send(2'b00, 3'b000, 6'd2, 1'b1, 1'b1, 10'h011, 9'h002);
    start      = 1'b0;
    chk("t6_count", 32'(word_count), 2);
    send(2'b11, 3'b110, 6'd0, 1'b1, 1'b0, '0, '0);
    chk("t6_err", 32'(err), 1);
    do_start(10'h050);
    chk("t6_err_clr", 32'(err), 0);
    chk("t6_busy", 32'(busy), 1);
    chk("t6_ec_clr", 32'(err_code), 0);
    chk("t6_count_clr", 32'(word_count), 0);

    // Reset sampled on the edge of an accept drops the write
    rq.req_valid   = 1'b1;
    rq.req_type    = 2'b00;
    rq.req_subop   = 3'b000;
    rq.req_operand = 6'h01;
    Reset          = 1'b1;
    tick();
    rq.req_valid = 1'b0;
    chk("t5_we", 32'(im_we), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_count", 32'(word_count), 0);
    chk("t5_addr", 32'(im_addr), 0);
    chk("t5_wdata", 32'(im_wdata), 0);
    chk("t5_ready", 32'(rq.req_ready), 0);
    Reset = 1'b0;
    repeat (2) tick();
    chk("t5_idle", 32'({busy, done, err}), 0);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
